text_frame_buffer: RTL and testbench

- Parametrised character frame buffer for the text-display path.
- Stores ROWS x COLS characters; characters arrive on a valid/ready stream.
- Keeps an internal cursor: auto-advance, line wrap, CR/LF/backspace handling, clear command, optional hardware scroll via a circular row base.
- A registered random-access read port serves the display scanner using logical (screen) coordinates.

---
 rtl/text_frame_buffer.sv | 183 ++++++++++++++++++
 tb/tb_text_frame_buffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_frame_buffer.sv
// Text frame buffer: cursor-driven character writes, CR/LF/BS, clear and circular-row scroll; rd_data 1 cycle after rd_row/rd_col.
// in_ready drops for the whole clear/scroll sweep and in any cycle with clear asserted.
module text_frame_buffer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ROWS       = 4,
  parameter int                    COLS       = 32,
  parameter bit                    SCROLL_EN  = 1'b1,
  parameter logic [DATA_WIDTH-1:0] FILL_CHAR  = 8'h20,
  parameter logic [DATA_WIDTH-1:0] CODE_CR    = 8'h0D,
  parameter logic [DATA_WIDTH-1:0] CODE_LF    = 8'h0A,
  parameter logic [DATA_WIDTH-1:0] CODE_BS    = 8'h08
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      in_ready,
  input  logic                      clear,
  input  logic [$clog2(ROWS)-1:0]   rd_row,
  input  logic [$clog2(COLS)-1:0]   rd_col,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic [$clog2(ROWS)-1:0]   cur_row,
  output logic [$clog2(COLS)-1:0]   cur_col,
  output logic                      busy
);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [RW-1:0] LAST_ROW      = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL      = CW'(COLS - 1);
  localparam logic [AW-1:0] LAST_CELL     = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LAST_ROW_CELL = AW'(COLS - 1);

  typedef enum logic [1:0] {IDLE, CLEAR_ALL, CLEAR_ROW} state_t;

  state_t                  state_q, state_d;
  logic [RW-1:0]           base_q, base_d;
  logic [RW-1:0]           row_q, row_d;
  logic [CW-1:0]           col_q, col_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic [RW-1:0]           clr_row_q, clr_row_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [DATA_WIDTH-1:0]   wr_dat;
  logic                    adv_line;
  logic                    rd_oob;
  logic [AW-1:0]           rd_addr;

  // Logical-to-physical row: the base rotates instead of moving data on scroll.
  function automatic logic [RW-1:0] phys(input logic [RW-1:0] base, input logic [RW-1:0] lrow);
    logic [RW:0] sum;
    sum = {1'b0, base} + {1'b0, lrow};
    if (sum >= (RW+1)'(ROWS)) sum = sum - (RW+1)'(ROWS);
    return sum[RW-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction

  assign in_ready = (state_q == IDLE) && !clear;
  assign busy     = (state_q != IDLE);
  assign cur_row  = row_q;
  assign cur_col  = col_q;
  assign rd_data  = rd_data_q;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    row_d     = row_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    clr_row_d = clr_row_q;
    wr_en     = 1'b0;
    wr_addr   = cell_addr(phys(base_q, row_q), col_q);
    wr_dat    = in_data;
    adv_line  = 1'b0;

    case (state_q)
      CLEAR_ALL: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_dat  = FILL_CHAR;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CELL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      CLEAR_ROW: begin
        wr_en   = 1'b1;
        wr_addr = cell_addr(clr_row_q, cnt_q[CW-1:0]);
        wr_dat  = FILL_CHAR;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_ROW_CELL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (clear) begin
          row_d   = '0;
          col_d   = '0;
          base_d  = '0;
          cnt_d   = '0;
          state_d = CLEAR_ALL;
        end else if (in_valid) begin
          if (in_data == CODE_CR) begin
            col_d = '0;
          end else if (in_data == CODE_LF) begin
            col_d    = '0;
            adv_line = 1'b1;
          end else if (in_data == CODE_BS) begin
            // Backspace stops at column 0; it never pulls the cursor up a line.
            if (col_q != '0) begin
              col_d   = col_q - 1'b1;
              wr_en   = 1'b1;
              wr_addr = cell_addr(phys(base_q, row_q), col_q - 1'b1);
              wr_dat  = FILL_CHAR;
            end
          end else begin
            wr_en = 1'b1;
            if (col_q == LAST_COL) begin
              col_d    = '0;
              adv_line = 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (adv_line) begin
      if (row_q != LAST_ROW) begin
        row_d = row_q + 1'b1;
      end else begin
        // The row being cleared is phys(0) now, which becomes the new bottom row after a scroll.
        clr_row_d = base_q;
        cnt_d     = '0;
        state_d   = CLEAR_ROW;
        if (SCROLL_EN) base_d = (base_q == LAST_ROW) ? '0 : base_q + 1'b1;
        else           row_d  = '0;
      end
    end
  end

  always_comb begin
    rd_oob    = (32'(rd_row) >= ROWS) || (32'(rd_col) >= COLS);
    rd_addr   = rd_oob ? '0 : cell_addr(phys(base_q, rd_row), rd_col);
    rd_data_d = rd_oob ? FILL_CHAR : mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR_ALL;
      base_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      cnt_q     <= '0;
      clr_row_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      row_q     <= row_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      clr_row_q <= clr_row_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[wr_addr] <= wr_dat;
  end

endmodule

// File: tb/tb_text_frame_buffer.sv
// Bench for text_frame_buffer: 4x32 scrolling, 4x32 wrapping and 3x5 scrolling instances share one stimulus stream
// and are each compared every cycle against a screen-array reference model.
module tb_text_frame_buffer;
  localparam logic [7:0] FILL = 8'h20;
  localparam logic [7:0] CR   = 8'h0D;
  localparam logic [7:0] LF   = 8'h0A;
  localparam logic [7:0] BS   = 8'h08;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset    = 1'b1;
  logic       in_valid = 1'b0;
  logic       clear    = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic [1:0] rd_row   = 2'd0;
  logic [4:0] rd_col   = 5'd0;

  logic       rdy0, rdy1, rdy2, bsy0, bsy1, bsy2;
  logic [7:0] rdd0, rdd1, rdd2;
  logic [1:0] cr0, cr1, cr2;
  logic [4:0] cc0, cc1;
  logic [2:0] cc2;

  text_frame_buffer #(.ROWS(4), .COLS(32), .SCROLL_EN(1'b1)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
    .clear(clear), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rdd0),
    .cur_row(cr0), .cur_col(cc0), .busy(bsy0));

  text_frame_buffer #(.ROWS(4), .COLS(32), .SCROLL_EN(1'b0)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .clear(clear), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rdd1),
    .cur_row(cr1), .cur_col(cc1), .busy(bsy1));

  text_frame_buffer #(.ROWS(3), .COLS(5), .SCROLL_EN(1'b1)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy2),
    .clear(clear), .rd_row(rd_row), .rd_col(rd_col[2:0]), .rd_data(rdd2),
    .cur_row(cr2), .cur_col(cc2), .busy(bsy2));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: screen held in logical row order; a scroll physically shifts rows up.
  int         R[3] = '{4, 4, 3};
  int         C[3] = '{32, 32, 5};
  int         S[3] = '{1, 0, 1};
  logic [7:0] scr [3][4][32];
  int         crow[3], ccol[3], bl[3];
  logic [7:0] exp_rd[3];
  bit         rd_chk[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_row(input int i, input int r);
    for (int c = 0; c < 32; c++) scr[i][r][c] = FILL;
  endtask

  task automatic advance(input int i);
    if (crow[i] < R[i] - 1) begin
      crow[i]++;
    end else begin
      bl[i] = C[i];
      if (S[i] != 0) begin
        for (int r = 0; r < R[i] - 1; r++)
          for (int c = 0; c < 32; c++) scr[i][r][c] = scr[i][r+1][c];
        fill_row(i, R[i] - 1);
      end else begin
        crow[i] = 0;
        fill_row(i, 0);
      end
    end
  endtask

  task automatic model_edge(input int i);
    int rr, rc;
    if (reset) begin
      for (int r = 0; r < 4; r++) fill_row(i, r);
      crow[i] = 0; ccol[i] = 0; bl[i] = R[i] * C[i];
      rd_chk[i] = 1'b1; exp_rd[i] = 8'h00;
      return;
    end
    rr = int'(rd_row);
    rc = (i == 2) ? int'(rd_col[2:0]) : int'(rd_col);
    rd_chk[i] = (bl[i] == 0);
    exp_rd[i] = (rr >= R[i] || rc >= C[i]) ? FILL : scr[i][rr][rc];
    if (bl[i] > 0) begin
      bl[i]--;
    end else if (clear) begin
      for (int r = 0; r < 4; r++) fill_row(i, r);
      crow[i] = 0; ccol[i] = 0; bl[i] = R[i] * C[i];
    end else if (in_valid) begin
      if (in_data == CR) begin
        ccol[i] = 0;
      end else if (in_data == LF) begin
        ccol[i] = 0;
        advance(i);
      end else if (in_data == BS) begin
        if (ccol[i] > 0) begin
          ccol[i]--;
          scr[i][crow[i]][ccol[i]] = FILL;
        end
      end else begin
        scr[i][crow[i]][ccol[i]] = in_data;
        if (ccol[i] < C[i] - 1) ccol[i]++;
        else begin
          ccol[i] = 0;
          advance(i);
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] ob, ordy, orow, ocol, ord;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin ob = 32'(bsy0); ordy = 32'(rdy0); orow = 32'(cr0); ocol = 32'(cc0); ord = 32'(rdd0); end
        1:       begin ob = 32'(bsy1); ordy = 32'(rdy1); orow = 32'(cr1); ocol = 32'(cc1); ord = 32'(rdd1); end
        default: begin ob = 32'(bsy2); ordy = 32'(rdy2); orow = 32'(cr2); ocol = 32'(cc2); ord = 32'(rdd2); end
      endcase
      chk($sformatf("u%0d.busy", i), ob, 32'(bl[i] > 0));
      chk($sformatf("u%0d.in_ready", i), ordy, 32'(bl[i] == 0 && !clear));
      chk($sformatf("u%0d.cur_row", i), orow, 32'(crow[i]));
      chk($sformatf("u%0d.cur_col", i), ocol, 32'(ccol[i]));
      if (rd_chk[i]) chk($sformatf("u%0d.rd_data", i), ord, 32'(exp_rd[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_edge(i);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send(input logic [7:0] ch);
    in_valid = 1'b1;
    in_data  = ch;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bsy0 === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic expect_rd(input string tag, input int r, input int c, input logic [7:0] v0, input logic [7:0] v1);
    rd_row = 2'(r);
    rd_col = 5'(c);
    tick();
    chk({tag, ".u0"}, 32'(rdd0), 32'(v0));
    chk({tag, ".u1"}, 32'(rdd1), 32'(v1));
  endtask

  initial begin
    int n;
    int k;

    // Reset and initial sweep
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_idle(n);
    chk("reset_busy_cycles", 32'(n), 32'd128);
    expect_rd("rd_after_reset", 2, 17, 8'h20, 8'h20);

    // Printable characters and CR
    send(8'h41);
    send(8'h42);
    chk("cur_after_AB", {cr0, 3'b000, cc0}, {2'd0, 3'b000, 5'd2});
    expect_rd("rd00_A", 0, 0, 8'h41, 8'h41);
    expect_rd("rd01_B", 0, 1, 8'h42, 8'h42);
    send(CR);
    chk("cur_after_CR", {cr0, 3'b000, cc0}, {2'd0, 3'b000, 5'd0});
    expect_rd("rd01_after_CR", 0, 1, 8'h42, 8'h42);

    // Fill a whole row, then backspace at column 0 and after a character
    for (int i = 0; i < 32; i++) send(8'h78);
    chk("cur_after_row_fill", {cr0, 3'b000, cc0}, {2'd1, 3'b000, 5'd0});
    chk("busy_after_row_fill", 32'(bsy0), 32'd0);
    send(BS);
    chk("cur_after_BS_col0", {cr0, 3'b000, cc0}, {2'd1, 3'b000, 5'd0});
    send(8'h51);
    send(BS);
    chk("cur_after_Q_BS", {cr0, 3'b000, cc0}, {2'd1, 3'b000, 5'd0});
    expect_rd("rd10_after_BS", 1, 0, 8'h20, 8'h20);
    expect_rd("rd031_x", 0, 31, 8'h78, 8'h78);

    // Clear together with a valid character: character held until the sweep ends
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    clear = 1'b0;
    wait_idle(n);
    chk("clear_busy_cycles", 32'(n), 32'd128);
    tick();
    in_valid = 1'b0;
    chk("cur_after_Z", {cr0, 3'b000, cc0}, {2'd0, 3'b000, 5'd1});
    expect_rd("rd00_Z", 0, 0, 8'h5A, 8'h5A);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 32; c++) begin
        rd_row = 2'(r);
        rd_col = 5'(c);
        tick();
      end

    // Reset in the middle of a sweep restarts it from cell 0
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_idle(n);
    chk("midsweep_reset_busy_cycles", 32'(n), 32'd128);

    // Scroll (u0) versus wrap (u1) on overflow past the last row
    send(8'h30); send(LF);
    send(8'h31); send(LF);
    send(8'h32); send(LF);
    send(8'h33); send(LF);
    wait_idle(n);
    chk("scroll_busy_cycles", 32'(n), 32'd32);
    expect_rd("rd00_scroll", 0, 0, 8'h31, 8'h20);
    expect_rd("rd10_scroll", 1, 0, 8'h32, 8'h31);
    expect_rd("rd20_scroll", 2, 0, 8'h33, 8'h32);
    expect_rd("rd30_scroll", 3, 0, 8'h20, 8'h33);
    chk("cur_after_scroll_u0", {cr0, 3'b000, cc0}, {2'd3, 3'b000, 5'd0});
    chk("cur_after_wrap_u1", {cr1, 3'b000, cc1}, {2'd0, 3'b000, 5'd0});

    // Random traffic, including clears, resets and out-of-range reads
    for (int cyc = 0; cyc < 3000; cyc++) begin
      k        = int'($urandom_range(0, 9));
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = (k == 0) ? CR : (k == 1) ? LF : (k == 2) ? BS : 8'(8'h21 + $urandom_range(0, 90));
      clear    = ($urandom_range(0, 199) == 0);
      reset    = ($urandom_range(0, 799) == 0);
      rd_row   = 2'($urandom_range(0, 3));
      rd_col   = 5'($urandom_range(0, 31));
      tick();
    end
    reset    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
